// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter: FSM states and the port IDs
// carried in the read-tag FIFO.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyV,
    StBusyD
  } arb_state_e;

  localparam logic PORT_V = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// 1-bit tag FIFO recording which port owns each outstanding SDRAM read.
// Synchronous active-low reset; push and pop may occur in the same cycle.
module sdram_arb_tag_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic wdata_i,
  input  logic pop_i,
  output logic rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates a read-only video port and a read/write draw port onto one SDRAM
// controller, with anti-starvation for draw and in-order read-response routing.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned AW       = 25,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_PEND = 8,
  parameter int unsigned STARVE   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  // Video port
  input  logic [AW-1:0]   v_address,
  input  logic            v_read,
  output logic            v_waitrequest,
  output logic [DW-1:0]   v_readdata,
  output logic            v_readdatavalid,
  // Draw port
  input  logic [AW-1:0]   d_address,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [DW-1:0]   d_writedata,
  input  logic [DW/8-1:0] d_byteenable,
  output logic            d_waitrequest,
  output logic [DW-1:0]   d_readdata,
  output logic            d_readdatavalid,
  // Master port
  output logic [AW-1:0]   m_address,
  output logic            m_read,
  output logic            m_write,
  output logic [DW-1:0]   m_writedata,
  output logic [DW/8-1:0] m_byteenable,
  input  logic            m_waitrequest,
  input  logic [DW-1:0]   m_readdata,
  input  logic            m_readdatavalid,
  output logic            err_orphan
);

  localparam int unsigned StarveW = $clog2(STARVE + 1);
  localparam logic [StarveW-1:0] StarveMax = STARVE[StarveW-1:0];

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               err_q, err_d;

  logic fifo_full, fifo_empty, fifo_head;
  logic v_acc, d_acc, d_pend, v_elig, d_elig;
  logic tag_push, tag_data, tag_pop;

  assign v_acc  = (state_q == StBusyV) && !m_waitrequest;
  assign d_acc  = (state_q == StBusyD) && !m_waitrequest;
  assign d_pend = d_read || d_write;
  // Writes never consume a tag, so a full FIFO only blocks reads.
  assign v_elig = v_read && !fifo_full;
  assign d_elig = d_write || (d_read && !fifo_full);

  assign tag_push = v_acc || (d_acc && d_read && !d_write);
  assign tag_data = v_acc ? PORT_V : PORT_D;
  assign tag_pop  = m_readdatavalid && !fifo_empty;

  sdram_arb_tag_fifo #(
    .Depth (MAX_PEND)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (tag_push),
    .wdata_i (tag_data),
    .pop_i   (tag_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_elig && (starve_q == StarveMax)) begin
          state_d = StBusyD;
        end else if (v_elig) begin
          state_d = StBusyV;
        end else if (d_elig) begin
          state_d = StBusyD;
        end
      end
      StBusyV, StBusyD: begin
        if (!m_waitrequest) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    starve_d = starve_q;
    if (!d_pend || d_acc) begin
      starve_d = '0;
    end else if (v_acc && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end

    err_d = err_q || (m_readdatavalid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Command pass-through from the granted requester; gated so reset forces idle outputs.
  always_comb begin
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    m_byteenable = '0;
    if (reset_n) begin
      unique case (state_q)
        StBusyV: begin
          m_address = v_address;
          m_read    = v_read;
        end
        StBusyD: begin
          m_address    = d_address;
          m_read       = d_read && !d_write;
          m_write      = d_write;
          m_writedata  = d_writedata;
          m_byteenable = d_byteenable;
        end
        default: ;
      endcase
    end
  end

  assign v_waitrequest   = !(reset_n && (state_q == StBusyV) && !m_waitrequest);
  assign d_waitrequest   = !(reset_n && (state_q == StBusyD) && !m_waitrequest);
  assign v_readdata      = m_readdata;
  assign d_readdata      = m_readdata;
  assign v_readdatavalid = reset_n && tag_pop && (fifo_head == PORT_V);
  assign d_readdatavalid = reset_n && tag_pop && (fifo_head == PORT_D);
  assign err_orphan      = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter, checked against a port-level
// model: acceptance order, response ownership, starvation bound and orphan flag.
module tb_sdram_arbiter;

  localparam int AW       = 25;
  localparam int DW       = 16;
  localparam int MAX_PEND = 8;
  localparam int STARVE   = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   v_address, d_address, m_address;
  logic            v_read, v_waitrequest, v_readdatavalid;
  logic [DW-1:0]   v_readdata, d_readdata, d_writedata, m_writedata, m_readdata;
  logic            d_read, d_write, d_waitrequest, d_readdatavalid;
  logic [DW/8-1:0] d_byteenable, m_byteenable;
  logic            m_read, m_write, m_waitrequest, m_readdatavalid, err_orphan;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_PEND (MAX_PEND),
    .STARVE   (STARVE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .v_address       (v_address),
    .v_read          (v_read),
    .v_waitrequest   (v_waitrequest),
    .v_readdata      (v_readdata),
    .v_readdatavalid (v_readdatavalid),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_writedata     (d_writedata),
    .d_byteenable    (d_byteenable),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .err_orphan      (err_orphan)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: owners of accepted reads in issue order, SDRAM read
  // return queue, expected sticky orphan flag, video-grant streak while draw waits.
  int            ord_q[$];
  logic [DW-1:0] sdram_q[$];
  bit            exp_orphan = 1'b0;
  int            streak = 0;
  bit            auto_resp = 1'b0;
  int            resp_pct = 100;
  bit            v_acc, d_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    lo = a[DW-1:0];
    return lo ^ 16'hC3A5;
  endfunction

  // One clock: observe at the falling edge, then return 2 time units after the rising edge.
  task automatic tick();
    int p;
    @(negedge clk);
    v_acc = 1'b0;
    d_acc = 1'b0;
    if (reset_n) begin
      check("err_orphan", 32'(err_orphan), 32'(exp_orphan));
      if (m_readdatavalid) begin
        if (sdram_q.size() > 0) void'(sdram_q.pop_front());
        if (ord_q.size() == 0) begin
          check("orphan_v_rdv", 32'(v_readdatavalid), 32'd0);
          check("orphan_d_rdv", 32'(d_readdatavalid), 32'd0);
          exp_orphan = 1'b1;
        end else begin
          p = ord_q.pop_front();
          check("route_v_rdv", 32'(v_readdatavalid), 32'(p == 0));
          check("route_d_rdv", 32'(d_readdatavalid), 32'(p == 1));
          check("route_data", 32'(p == 0 ? v_readdata : d_readdata), 32'(m_readdata));
        end
      end else begin
        check("rdv_quiet", 32'(v_readdatavalid || d_readdatavalid), 32'd0);
      end
      check("single_grant", 32'(!v_waitrequest && !d_waitrequest), 32'd0);
      if (v_read && !v_waitrequest) begin
        v_acc = 1'b1;
        ord_q.push_back(0);
        check("v_cmd", 32'({m_read, m_write}), 32'b10);
        check("v_addr", 32'(m_address), 32'(v_address));
      end
      if ((d_read || d_write) && !d_waitrequest) begin
        d_acc = 1'b1;
        check("d_addr", 32'(m_address), 32'(d_address));
        if (d_write) begin
          check("d_wr_cmd", 32'({m_read, m_write}), 32'b01);
          check("d_wdata", 32'(m_writedata), 32'(d_writedata));
          check("d_be", 32'(m_byteenable), 32'(d_byteenable));
        end else begin
          ord_q.push_back(1);
          check("d_rd_cmd", 32'({m_read, m_write}), 32'b10);
        end
      end
      if (m_read && !m_waitrequest) sdram_q.push_back(rdata_of(m_address));
      if (!(d_read || d_write) || d_acc) streak = 0;
      else if (v_acc) streak++;
      check("starve_bound", 32'(streak <= STARVE), 32'd1);
      check("pend_bound", 32'(ord_q.size() <= MAX_PEND), 32'd1);
    end
    @(posedge clk);
    #2;
    if (auto_resp) begin
      if (sdram_q.size() > 0 && $urandom_range(99) < resp_pct) begin
        m_readdatavalid = 1'b1;
        m_readdata      = sdram_q[0];
      end else begin
        m_readdatavalid = 1'b0;
      end
    end
  endtask

  task automatic clear_inputs();
    v_read = 1'b0; v_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    auto_resp = 1'b0;
    ord_q.delete();
    sdram_q.delete();
    exp_orphan = 1'b0;
    streak = 0;
    // Requests and a stray response during reset must all be suppressed.
    v_read = 1'b1; d_write = 1'b1; m_readdatavalid = 1'b1; m_waitrequest = 1'b0;
    tick();
    tick();
    #1;
    check("rst_m_cmd", 32'({m_read, m_write}), 32'd0);
    check("rst_v_wait", 32'(v_waitrequest), 32'd1);
    check("rst_d_wait", 32'(d_waitrequest), 32'd1);
    check("rst_rdv", 32'({v_readdatavalid, d_readdatavalid}), 32'd0);
    check("rst_orphan", 32'(err_orphan), 32'd0);
    clear_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic issue(input bit port, input logic [AW-1:0] a);
    bit got = 1'b0;
    if (port) begin d_read = 1'b1; d_address = a; end
    else begin v_read = 1'b1; v_address = a; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = port ? d_acc : v_acc;
    end
    v_read = 1'b0;
    d_read = 1'b0;
    check("issue_accept", 32'(got), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] rsp[3];
    int            owner[3];
    int            cnt;
    bit            got;
    int            r;

    clear_inputs();
    reset_n = 1'b0;
    do_reset();

    // Simultaneous video read and draw write: video first, draw two cycles later.
    v_read = 1'b1; v_address = 25'h100;
    d_write = 1'b1; d_address = 25'h200; d_writedata = 16'h1234; d_byteenable = 2'b11;
    #1;
    check("idle_no_cmd", 32'({m_read, m_write}), 32'd0);
    tick();
    #1;
    check("first_is_video", 32'(m_address), 32'h100);
    check("first_v_read", 32'(m_read), 32'd1);
    check("first_d_wait", 32'(d_waitrequest), 32'd1);
    tick();
    check("v_accepted", 32'(v_acc), 32'd1);
    v_read = 1'b0;
    #1;
    check("gap_idle", 32'({m_read, m_write}), 32'd0);
    tick();
    #1;
    check("second_is_draw", 32'(m_address), 32'h200);
    check("second_write", 32'(m_write), 32'd1);
    tick();
    check("d_accepted", 32'(d_acc), 32'd1);
    d_write = 1'b0;
    auto_resp = 1'b1;
    repeat (4) tick();
    check("drain_029", 32'(ord_q.size()), 32'd0);

    // Back-to-back video with draw read held: draw forced after STARVE grants.
    d_read = 1'b1; d_address = 25'h2A0;
    v_read = 1'b1; v_address = 25'h400;
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (d_acc) got = 1'b1;
      else if (v_acc) begin cnt++; v_address = v_address + 1'b1; end
    end
    v_read = 1'b0; d_read = 1'b0;
    check("starve_draw_granted", 32'(got), 32'd1);
    check("starve_video_grants", 32'(cnt), 32'(STARVE));
    repeat (6) tick();
    check("drain_030", 32'(ord_q.size()), 32'd0);

    // Fill the tag FIFO with no responses: reads stall, a draw write still passes.
    auto_resp = 1'b0; m_readdatavalid = 1'b0;
    v_read = 1'b1; v_address = 25'h500;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < MAX_PEND; i++) begin
      tick();
      if (v_acc) begin cnt++; v_address = v_address + 1'b1; end
    end
    check("fill_count", 32'(cnt), 32'(MAX_PEND));
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("full_v_wait", 32'(v_waitrequest), 32'd1);
      check("full_no_read", 32'(m_read), 32'd0);
    end
    d_write = 1'b1; d_address = 25'h600; d_writedata = 16'h7777; d_byteenable = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = d_acc;
    end
    check("full_write_accepted", 32'(got), 32'd1);
    d_write = 1'b0; v_read = 1'b0;
    auto_resp = 1'b1;
    repeat (14) tick();
    check("drain_031", 32'(ord_q.size()), 32'd0);

    // Interleaved V, D, V reads with directed response data.
    auto_resp = 1'b0; m_readdatavalid = 1'b0;
    issue(1'b0, 25'h10);
    issue(1'b1, 25'h20);
    issue(1'b0, 25'h30);
    rsp[0] = 16'hAAAA; rsp[1] = 16'hBBBB; rsp[2] = 16'hCCCC;
    owner[0] = 0; owner[1] = 1; owner[2] = 0;
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1'b1; m_readdata = rsp[i];
      #1;
      check("ilv_v_rdv", 32'(v_readdatavalid), 32'(owner[i] == 0));
      check("ilv_d_rdv", 32'(d_readdatavalid), 32'(owner[i] == 1));
      check("ilv_data", 32'(owner[i] == 0 ? v_readdata : d_readdata), 32'(rsp[i]));
      tick();
    end
    m_readdatavalid = 1'b0;
    tick();
    check("drain_032", 32'(ord_q.size()), 32'd0);

    // Held draw write (read also set) under m_waitrequest for 5 cycles.
    m_waitrequest = 1'b1;
    d_write = 1'b1; d_read = 1'b1; d_address = 25'h3C0; d_writedata = 16'hBEEF;
    d_byteenable = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_cmd", 32'({m_read, m_write}), 32'b01);
      check("hold_addr", 32'(m_address), 32'h3C0);
      check("hold_wdata", 32'(m_writedata), 32'hBEEF);
      check("hold_d_wait", 32'(d_waitrequest), 32'd1);
      tick();
    end
    m_waitrequest = 1'b0;
    #1;
    check("hold_release", 32'(d_waitrequest), 32'd0);
    tick();
    check("hold_accepted", 32'(d_acc), 32'd1);
    d_write = 1'b0; d_read = 1'b0;
    #1;
    check("hold_back_idle", 32'({m_read, m_write, d_waitrequest}), 32'b001);

    // Reset with a read outstanding, then a response nobody owns.
    issue(1'b0, 25'h40);
    do_reset();
    m_readdatavalid = 1'b1; m_readdata = 16'h5555;
    #1;
    check("orphan_no_rdv", 32'({v_readdatavalid, d_readdatavalid}), 32'd0);
    tick();
    m_readdatavalid = 1'b0;
    tick();
    check("orphan_set", 32'(err_orphan), 32'd1);
    repeat (4) tick();
    check("orphan_sticky", 32'(err_orphan), 32'd1);
    do_reset();

    // Randomized traffic with random back-pressure and response gaps.
    auto_resp = 1'b1;
    resp_pct = 70;
    for (int c = 0; c < 800; c++) begin
      m_waitrequest = ($urandom_range(3) == 0);
      if (!v_read || v_acc) begin
        v_read = ($urandom_range(2) != 0);
        v_address = AW'($urandom);
      end
      if (!(d_read || d_write) || d_acc) begin
        r = $urandom_range(5);
        d_read = (r == 1) || (r == 3);
        d_write = (r == 2) || (r == 3);
        d_address = AW'($urandom);
        d_writedata = DW'($urandom);
        d_byteenable = 2'($urandom_range(3));
      end
      tick();
    end
    v_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_waitrequest = 1'b0;
    resp_pct = 100;
    repeat (20) tick();
    check("drain_random", 32'(ord_q.size()), 32'd0);
    check("sdram_q_empty", 32'(sdram_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
